ip_tx_resolver: RTL and testbench

//  Next-hop resolver and header gate for the IPv4 transmit path, sitting between the IP source and ip_eth_tx.

---
 rtl/ip_tx_resolver.sv | 214 +++++++++++++++++++++
 tb/tb_ip_tx_resolver.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_tx_resolver.sv
// ip_tx_resolver: next-hop resolver and header gate for the IPv4 transmit path.
// It classifies each outgoing destination as multicast, broadcast, on-subnet or via the gateway.
// It resolves the next hop to a MAC through a small fully associative cache, or through ARP on a
// miss, and forwards one header per packet to ip_eth_tx.
// Packets that cannot be resolved (ARP error or timeout) are dropped: the header is acked
// upstream, no header goes downstream, and the payload is drained.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   s_ip_hdr_*                   header from IP source (valid/ready pulse, destination IP)
//   s_ip_payload_axis_*          payload beats from IP source (only tvalid/tlast/tready observed)
//   m_hdr_*, m_eth_dest_mac      header to ip_eth_tx with resolved destination MAC
//   m_payload_axis_tready        payload ready from ip_eth_tx
//   arp_request_*, arp_response_*  ARP block interface
//   local_ip, subnet_mask, gateway_ip  network configuration
//   cache_flush                  invalidate all cache entries
//   tx_error_arp_*, cache_hit    one-cycle status pulses
module ip_tx_resolver #(
  parameter int unsigned CACHE_DEPTH = 4,
  parameter int unsigned TIMEOUT_W   = 16,
  parameter int unsigned ARP_TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_ip_hdr_valid,
  output logic        s_ip_hdr_ready,
  input  logic [31:0] s_ip_dest_ip,
  input  logic        s_ip_payload_axis_tvalid,
  input  logic        s_ip_payload_axis_tlast,
  output logic        s_ip_payload_axis_tready,
  output logic        m_hdr_valid,
  input  logic        m_hdr_ready,
  output logic [47:0] m_eth_dest_mac,
  input  logic        m_payload_axis_tready,
  output logic        arp_request_valid,
  input  logic        arp_request_ready,
  output logic [31:0] arp_request_ip,
  input  logic        arp_response_valid,
  output logic        arp_response_ready,
  input  logic        arp_response_error,
  input  logic [47:0] arp_response_mac,
  input  logic [31:0] local_ip,
  input  logic [31:0] subnet_mask,
  input  logic [31:0] gateway_ip,
  input  logic        cache_flush,
  output logic        tx_error_arp_failed,
  output logic        tx_error_arp_timeout,
  output logic        cache_hit
);

  localparam int unsigned PtrW = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StArpQuery, StWaitPacket} state_e;

  state_e                 state_q;
  logic                   drop_q;
  logic [TIMEOUT_W-1:0]   cnt_q;
  logic [PtrW-1:0]        ptr_q;
  logic                   cache_valid_q [CACHE_DEPTH];
  logic [31:0]            cache_ip_q    [CACHE_DEPTH];
  logic [47:0]            cache_mac_q   [CACHE_DEPTH];

  // Classification of the offered destination
  logic        is_mcast;
  logic        is_bcast;
  logic        on_subnet;
  logic [31:0] next_hop;
  logic [47:0] mcast_mac;

  assign is_mcast  = (s_ip_dest_ip[31:28] == 4'hE);
  assign is_bcast  = (s_ip_dest_ip == 32'hFFFF_FFFF) ||
                     (s_ip_dest_ip == (local_ip | ~subnet_mask));
  assign on_subnet = (((s_ip_dest_ip ^ local_ip) & subnet_mask) == 32'h0);
  assign next_hop  = on_subnet ? s_ip_dest_ip : gateway_ip;
  assign mcast_mac = {24'h01005E, 1'b0, s_ip_dest_ip[22:0]};

  // Two lookups: next_hop for the header path, arp_request_ip to decide update-in-place on a
  // successful response. Scanning downwards lets the lowest matching index win.
  logic            hop_hit;
  logic [47:0]     hop_mac;
  logic            upd_hit;
  logic [PtrW-1:0] upd_idx;

  always_comb begin
    hop_hit = 1'b0;
    hop_mac = '0;
    upd_hit = 1'b0;
    upd_idx = '0;
    for (int i = int'(CACHE_DEPTH) - 1; i >= 0; i--) begin
      if (cache_valid_q[i] && (cache_ip_q[i] == next_hop)) begin
        hop_hit = 1'b1;
        hop_mac = cache_mac_q[i];
      end
      if (cache_valid_q[i] && (cache_ip_q[i] == arp_request_ip)) begin
        upd_hit = 1'b1;
        upd_idx = PtrW'(i);
      end
    end
  end

  logic resp_fire;
  logic timeout_hit;
  logic cache_wr;

  assign resp_fire   = arp_response_valid && arp_response_ready;
  assign timeout_hit = (cnt_q == TIMEOUT_W'(ARP_TIMEOUT - 1));
  assign cache_wr    = (state_q == StArpQuery) && resp_fire && !arp_response_error;

  assign s_ip_payload_axis_tready = (state_q == StWaitPacket) && (m_payload_axis_tready || drop_q);

  // MAC cache; a flush takes priority over a coincident write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < int'(CACHE_DEPTH); i++) begin
        cache_valid_q[i] <= 1'b0;
        cache_ip_q[i]    <= '0;
        cache_mac_q[i]   <= '0;
      end
    end else if (cache_flush) begin
      for (int i = 0; i < int'(CACHE_DEPTH); i++) begin
        cache_valid_q[i] <= 1'b0;
      end
    end else if (cache_wr) begin
      if (upd_hit) begin
        cache_mac_q[upd_idx] <= arp_response_mac;
      end else begin
        cache_valid_q[ptr_q] <= 1'b1;
        cache_ip_q[ptr_q]    <= arp_request_ip;
        cache_mac_q[ptr_q]   <= arp_response_mac;
        ptr_q <= (ptr_q == PtrW'(CACHE_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
      end
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= StIdle;
      drop_q               <= 1'b0;
      cnt_q                <= '0;
      s_ip_hdr_ready       <= 1'b0;
      m_hdr_valid          <= 1'b0;
      m_eth_dest_mac       <= '0;
      arp_request_valid    <= 1'b0;
      arp_request_ip       <= '0;
      arp_response_ready   <= 1'b0;
      tx_error_arp_failed  <= 1'b0;
      tx_error_arp_timeout <= 1'b0;
      cache_hit            <= 1'b0;
    end else begin
      s_ip_hdr_ready       <= 1'b0;
      tx_error_arp_failed  <= 1'b0;
      tx_error_arp_timeout <= 1'b0;
      cache_hit            <= 1'b0;
      if (m_hdr_valid && m_hdr_ready) begin
        m_hdr_valid <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (s_ip_hdr_valid) begin
            if (is_mcast || is_bcast || hop_hit) begin
              s_ip_hdr_ready <= 1'b1;
              m_hdr_valid    <= 1'b1;
              m_eth_dest_mac <= is_mcast ? mcast_mac :
                                is_bcast ? 48'hFFFF_FFFF_FFFF : hop_mac;
              cache_hit      <= !is_mcast && !is_bcast;
              state_q        <= StWaitPacket;
            end else begin
              arp_request_ip     <= next_hop;
              arp_request_valid  <= 1'b1;
              arp_response_ready <= 1'b1;
              cnt_q              <= '0;
              state_q            <= StArpQuery;
            end
          end
        end

        StArpQuery: begin
          cnt_q <= cnt_q + 1'b1;
          if (arp_request_valid && arp_request_ready) begin
            arp_request_valid <= 1'b0;
          end
          // A response in the timeout cycle still wins
          if (resp_fire || timeout_hit) begin
            arp_request_valid  <= 1'b0;
            arp_response_ready <= 1'b0;
            s_ip_hdr_ready     <= 1'b1;
            state_q            <= StWaitPacket;
            if (resp_fire && !arp_response_error) begin
              m_hdr_valid    <= 1'b1;
              m_eth_dest_mac <= arp_response_mac;
            end else begin
              drop_q               <= 1'b1;
              tx_error_arp_failed  <= resp_fire;
              tx_error_arp_timeout <= !resp_fire;
            end
          end
        end

        StWaitPacket: begin
          if (s_ip_payload_axis_tvalid && s_ip_payload_axis_tready && s_ip_payload_axis_tlast) begin
            drop_q  <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_tx_resolver.sv
module tb_ip_tx_resolver;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = 16;
  localparam int unsigned TO    = 20;

  localparam logic [31:0] LOCAL = 32'hC0A8_010A;
  localparam logic [31:0] MASK  = 32'hFFFF_FF00;
  localparam logic [31:0] GW    = 32'hC0A8_0101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_ip_hdr_valid = 1'b0;
  logic        s_ip_hdr_ready;
  logic [31:0] s_ip_dest_ip = '0;
  logic        s_ip_payload_axis_tvalid = 1'b0;
  logic        s_ip_payload_axis_tlast = 1'b0;
  logic        s_ip_payload_axis_tready;
  logic        m_hdr_valid;
  logic        m_hdr_ready = 1'b0;
  logic [47:0] m_eth_dest_mac;
  logic        m_payload_axis_tready = 1'b0;
  logic        arp_request_valid;
  logic        arp_request_ready = 1'b0;
  logic [31:0] arp_request_ip;
  logic        arp_response_valid = 1'b0;
  logic        arp_response_ready;
  logic        arp_response_error = 1'b0;
  logic [47:0] arp_response_mac = '0;
  logic [31:0] local_ip = LOCAL;
  logic [31:0] subnet_mask = MASK;
  logic [31:0] gateway_ip = GW;
  logic        cache_flush = 1'b0;
  logic        tx_error_arp_failed;
  logic        tx_error_arp_timeout;
  logic        cache_hit;

  always #5 clk = ~clk;

  ip_tx_resolver #(
    .CACHE_DEPTH(DEPTH),
    .TIMEOUT_W  (TW),
    .ARP_TIMEOUT(TO)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .s_ip_hdr_valid          (s_ip_hdr_valid),
    .s_ip_hdr_ready          (s_ip_hdr_ready),
    .s_ip_dest_ip            (s_ip_dest_ip),
    .s_ip_payload_axis_tvalid(s_ip_payload_axis_tvalid),
    .s_ip_payload_axis_tlast (s_ip_payload_axis_tlast),
    .s_ip_payload_axis_tready(s_ip_payload_axis_tready),
    .m_hdr_valid             (m_hdr_valid),
    .m_hdr_ready             (m_hdr_ready),
    .m_eth_dest_mac          (m_eth_dest_mac),
    .m_payload_axis_tready   (m_payload_axis_tready),
    .arp_request_valid       (arp_request_valid),
    .arp_request_ready       (arp_request_ready),
    .arp_request_ip          (arp_request_ip),
    .arp_response_valid      (arp_response_valid),
    .arp_response_ready      (arp_response_ready),
    .arp_response_error      (arp_response_error),
    .arp_response_mac        (arp_response_mac),
    .local_ip                (local_ip),
    .subnet_mask             (subnet_mask),
    .gateway_ip              (gateway_ip),
    .cache_flush             (cache_flush),
    .tx_error_arp_failed     (tx_error_arp_failed),
    .tx_error_arp_timeout    (tx_error_arp_timeout),
    .cache_hit               (cache_hit)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome of one packet: kind 0 = header forwarded, 1 = ARP failed, 2 = ARP timeout
  typedef struct {
    int          kind;
    logic [47:0] mac;
    bit          arp;
    logic [31:0] arp_ip;
    bit          hit;
  } exp_t;

  exp_t sb[$];
  int   exp_hs = 0;

  // Reference cache: oldest insertion at the front
  logic [31:0] m_ip[$];
  logic [47:0] m_mac[$];

  function automatic int model_find(input logic [31:0] ip);
    for (int i = 0; i < m_ip.size(); i++) if (m_ip[i] == ip) return i;
    return -1;
  endfunction

  function automatic exp_t predict(input logic [31:0] d, input int rkind, input logic [47:0] rmac);
    exp_t        e;
    logic [31:0] hop;
    int          idx;
    e.kind = 0; e.mac = '0; e.arp = 0; e.arp_ip = '0; e.hit = 0;
    if (d[31:28] == 4'hE) begin
      e.mac = {24'h01005E, 1'b0, d[22:0]};
    end else if (d == 32'hFFFF_FFFF || d == (LOCAL | ~MASK)) begin
      e.mac = 48'hFFFF_FFFF_FFFF;
    end else begin
      hop = (((d ^ LOCAL) & MASK) == 0) ? d : GW;
      idx = model_find(hop);
      if (idx >= 0) begin
        e.hit = 1;
        e.mac = m_mac[idx];
      end else begin
        e.arp    = 1;
        e.arp_ip = hop;
        e.kind   = rkind;
        e.mac    = rmac;
        if (rkind == 0) begin
          if (m_ip.size() == DEPTH) begin
            void'(m_ip.pop_front());
            void'(m_mac.pop_front());
          end
          m_ip.push_back(hop);
          m_mac.push_back(rmac);
        end
      end
    end
    return e;
  endfunction

  // Monitor / scoreboard
  int          since_valid, since_resp, since_req, hs_count;
  bit          prev_valid, prev_req, prev_req_hs, saw_arp;
  logic [31:0] arp_ip_seen;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      since_valid = 0; since_resp = 0; since_req = 0;
      prev_valid = 0; prev_req = 0; prev_req_hs = 0; saw_arp = 0;
    end else begin
      since_valid++; since_resp++; since_req++;
      if (prev_req_hs) chk("arp_req_fall", arp_request_valid, 0);
      if (s_ip_hdr_valid && !prev_valid) since_valid = 0;
      if (arp_response_valid && arp_response_ready) since_resp = 0;
      if (arp_request_valid && !prev_req) begin
        since_req = 0; saw_arp = 1; arp_ip_seen = arp_request_ip;
      end
      if (m_hdr_valid && m_hdr_ready) hs_count++;
      if (cache_hit) chk("stray_cache_hit", s_ip_hdr_ready, 1);
      if (s_ip_hdr_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_hdr_ready", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("cache_hit", cache_hit, e.hit);
          chk("arp_issued", saw_arp, e.arp);
          if (e.arp) chk("arp_request_ip", arp_ip_seen, e.arp_ip);
          case (e.kind)
            0: begin
              chk("m_hdr_valid", m_hdr_valid, 1);
              chk("m_eth_dest_mac", m_eth_dest_mac, e.mac);
              chk("tx_errors", {tx_error_arp_failed, tx_error_arp_timeout}, 0);
            end
            1: begin
              chk("m_hdr_valid_drop", m_hdr_valid, 0);
              chk("arp_failed", {tx_error_arp_failed, tx_error_arp_timeout}, 2'b10);
            end
            default: begin
              chk("m_hdr_valid_drop", m_hdr_valid, 0);
              chk("arp_timeout", {tx_error_arp_failed, tx_error_arp_timeout}, 2'b01);
              chk("arp_idle_after_timeout", {arp_request_valid, arp_response_ready}, 0);
            end
          endcase
          if (!e.arp) chk("hit_latency", since_valid, 1);
          else if (e.kind == 2) chk("timeout_latency", since_req, TO);
          else chk("resp_latency", since_resp, 1);
          saw_arp = 0;
        end
      end
      prev_valid  = s_ip_hdr_valid;
      prev_req    = arp_request_valid;
      prev_req_hs = arp_request_valid && arp_request_ready;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 m_hdr_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_payload(input int nbeats, input bit drop);
    bit acc;
    for (int b = 0; b < nbeats; b++) begin
      s_ip_payload_axis_tvalid = 1'b1;
      s_ip_payload_axis_tlast  = (b == nbeats - 1);
      acc = 0;
      for (int c = 0; c < 20 && !acc; c++) begin
        m_payload_axis_tready = drop ? 1'b0 : 1'($urandom_range(0, 1));
        #1;
        chk("payload_tready", s_ip_payload_axis_tready, drop ? 1'b1 : m_payload_axis_tready);
        acc = s_ip_payload_axis_tready;
        @(posedge clk);
        #1;
      end
      if (!acc) chk("payload_beat_timeout", 0, 1);
    end
    s_ip_payload_axis_tvalid = 1'b0;
    s_ip_payload_axis_tlast  = 1'b0;
    m_payload_axis_tready    = 1'b0;
  endtask

  // rkind: 0 = ARP success, 1 = ARP error, 2 = ARP silent
  task automatic send_pkt(input logic [31:0] dest, input int rkind, input int delay,
                          input logic [47:0] rmac, input int nbeats);
    exp_t e;
    bit   seen;
    e = predict(dest, rkind, rmac);
    sb.push_back(e);
    if (e.kind == 0) exp_hs++;
    s_ip_dest_ip   = dest;
    s_ip_hdr_valid = 1'b1;
    if (e.arp) begin
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        tick();
        seen = arp_request_valid;
      end
      if (!seen) chk("arp_request_wait", 0, 1);
      if (rkind != 2) begin
        arp_request_ready = 1'b1;
        tick();
        arp_request_ready = 1'b0;
        for (int c = 1; c < delay; c++) tick();
        arp_response_valid = 1'b1;
        arp_response_error = (rkind == 1);
        arp_response_mac   = rmac;
        tick();
        arp_response_valid = 1'b0;
        arp_response_error = 1'b0;
      end
    end
    seen = s_ip_hdr_ready;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      seen = s_ip_hdr_ready;
    end
    if (!seen) chk("hdr_ready_wait", 0, 1);
    s_ip_hdr_valid = 1'b0;
    if (e.kind == 0) begin
      for (int c = 0; c < 50 && m_hdr_valid; c++) tick();
      chk("m_hdr_accepted", m_hdr_valid, 0);
    end
    send_payload(nbeats, e.kind != 0);
  endtask

  task automatic flush();
    cache_flush = 1'b1;
    tick();
    cache_flush = 1'b0;
    m_ip.delete();
    m_mac.delete();
  endtask

  logic [31:0] pool [10];

  initial begin
    int   pick, rk;
    exp_t dummy;
    bit   seen;

    #2;
    chk("rst_hdr_ready", s_ip_hdr_ready, 0);
    chk("rst_m_hdr_valid", m_hdr_valid, 0);
    chk("rst_mac", m_eth_dest_mac, 0);
    chk("rst_arp_req", {arp_request_valid, arp_response_ready}, 0);
    chk("rst_arp_ip", arp_request_ip, 0);
    chk("rst_pulses", {tx_error_arp_failed, tx_error_arp_timeout, cache_hit}, 0);
    chk("rst_payload_tready", s_ip_payload_axis_tready, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    send_pkt(32'hC0A8_0114, 0, 5, 48'h0200_0000_0001, 3);
    send_pkt(32'hC0A8_0114, 0, 5, 48'h0, 2);
    send_pkt(32'h0808_0808, 0, 3, 48'h0200_0000_0002, 1);
    send_pkt(32'hEF81_0203, 0, 1, 48'h0, 2);
    send_pkt(32'hC0A8_01FF, 0, 1, 48'h0, 1);
    send_pkt(32'hC0A8_0133, 2, 1, 48'h0, 3);
    send_pkt(32'hC0A8_0134, 1, 4, 48'h0, 2);
    // Fill past capacity, then revisit the evicted hop
    send_pkt(32'hC0A8_0121, 0, 2, 48'h0200_0000_0021, 1);
    send_pkt(32'hC0A8_0122, 0, 2, 48'h0200_0000_0022, 1);
    send_pkt(32'hC0A8_0123, 0, 2, 48'h0200_0000_0023, 1);
    send_pkt(32'hC0A8_0114, 0, 2, 48'h0200_0000_0041, 1);
    send_pkt(32'hC0A8_0123, 0, 2, 48'h0, 1);
    flush();
    send_pkt(32'hC0A8_0123, 0, 2, 48'h0200_0000_0053, 1);

    // Reset in the middle of an ARP query abandons the packet and empties the cache
    dummy = predict(32'hC0A8_0140, 0, 48'h0);
    s_ip_dest_ip   = 32'hC0A8_0140;
    s_ip_hdr_valid = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = arp_request_valid;
    end
    chk("abort_arp_seen", seen, 1);
    rst_n = 1'b0;
    s_ip_hdr_valid = 1'b0;
    #1;
    chk("abort_outputs", {arp_request_valid, arp_response_ready, m_hdr_valid, s_ip_hdr_ready}, 0);
    chk("abort_arp_ip", arp_request_ip, 0);
    m_ip.delete();
    m_mac.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    send_pkt(32'hC0A8_0123, 0, 2, 48'h0200_0000_0063, 1);

    pool[0] = 32'hC0A8_0114; pool[1] = 32'hC0A8_0115; pool[2] = 32'hC0A8_0116;
    pool[3] = 32'hC0A8_0117; pool[4] = 32'hC0A8_0118; pool[5] = 32'h0808_0808;
    pool[6] = 32'h0102_0304; pool[7] = 32'hE000_00FB; pool[8] = 32'hFFFF_FFFF;
    pool[9] = 32'hC0A8_01FF;
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 9);
      rk   = $urandom_range(0, 19);
      rk   = (rk < 14) ? 0 : (rk < 17) ? 1 : 2;
      if ($urandom_range(0, 9) == 0) flush();
      send_pkt(pool[pick], rk, $urandom_range(1, 10), {16'h0200, 32'($urandom)},
               $urandom_range(1, 4));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (5) tick();
    chk("scoreboard_empty", sb.size(), 0);
    chk("m_hdr_handshakes", hs_count, exp_hs);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

endmodule
